// File: rtl/rsa_pkg.sv
// Shared types and output decode for the RSA exponentiation sequencer.
package rsa_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LOAD     = 4'd1,
        CHECK    = 4'd2,
        MUL      = 4'd3,
        MUL_WAIT = 4'd4,
        SQR      = 4'd5,
        SQR_WAIT = 4'd6,
        SHIFT    = 4'd7,
        DONE     = 4'd8,
        ABORT    = 4'd9
    } exp_state_t;

    localparam logic MUL_OP_MULT   = 1'b0;
    localparam logic MUL_OP_SQUARE = 1'b1;

    typedef struct packed {
        logic sr_ena;
        logic sr_clear;
        logic sr_load;
        logic mul_start;
        logic mul_op;
        logic busy;
        logic done;
    } ctrl_out_t;

    // Moore output decode; evaluated on the next state so outputs can be registered.
    function automatic ctrl_out_t decode_outputs(input exp_state_t s);
        ctrl_out_t o;
        o = '{sr_ena: 1'b0, sr_clear: 1'b1, sr_load: 1'b0, mul_start: 1'b0,
              mul_op: MUL_OP_MULT, busy: 1'b1, done: 1'b0};
        case (s)
            IDLE:     o.busy = 1'b0;
            LOAD:     begin o.sr_ena = 1'b1; o.sr_load = 1'b1; end
            CHECK:    o.busy = 1'b1;
            MUL:      o.mul_start = 1'b1;
            MUL_WAIT: o.mul_op = MUL_OP_MULT;
            SQR:      begin o.mul_start = 1'b1; o.mul_op = MUL_OP_SQUARE; end
            SQR_WAIT: o.mul_op = MUL_OP_SQUARE;
            SHIFT:    o.sr_ena = 1'b1;
            DONE:     begin o.sr_ena = 1'b1; o.sr_clear = 1'b0; o.done = 1'b1; end
            ABORT:    begin o.sr_ena = 1'b1; o.sr_clear = 1'b0; end
            default:  o.busy = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rsa_bit_counter.sv
// Exponent bit index counter: clear, saturating increment, last-bit flag.
module rsa_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             last_s;

    assign last_s = (count_q == CNT_W'(WIDTH - 1));

    // Next count; increment stops at the last bit so the index stays in range.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {CNT_W{1'b0}};
        end else if (inc_i && !last_s) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = last_s;

endmodule

// File: rtl/rsa_exp_ctrl.sv
// Right-to-left binary modular exponentiation sequencer.
// Optional abort input enabled by defining RSA_EXP_ABORT_EN.
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             sr_bit,
    input  logic             mul_done,
`ifdef RSA_EXP_ABORT_EN
    input  logic             abort,
`endif
    output logic             sr_ena,
    output logic             sr_clear,
    output logic             sr_load,
    output logic             mul_start,
    output logic             mul_op,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_idx
);

    exp_state_t state_q;
    exp_state_t state_d;
    ctrl_out_t  out_q;
    ctrl_out_t  out_d;
    logic       cnt_clr_s;
    logic       cnt_inc_s;
    logic       last_s;

    rsa_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk     (clk),
        .rstb    (rstb),
        .clr_i   (cnt_clr_s),
        .inc_i   (cnt_inc_s),
        .count_o (bit_idx),
        .last_o  (last_s)
    );

    // Next-state and counter control.
    always_comb begin
        state_d   = state_q;
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        case (state_q)
            IDLE:     state_d = start ? LOAD : IDLE;
            LOAD:     begin cnt_clr_s = 1'b1; state_d = CHECK; end
            CHECK: begin
                if (sr_bit) begin
                    state_d = MUL;
                end else if (last_s) begin
                    state_d = DONE;
                end else begin
                    state_d = SQR;
                end
            end
            MUL:      state_d = MUL_WAIT;
            MUL_WAIT: begin
                if (mul_done) begin
                    state_d = last_s ? DONE : SQR;
                end else begin
                    state_d = MUL_WAIT;
                end
            end
            SQR:      state_d = SQR_WAIT;
            SQR_WAIT: state_d = mul_done ? SHIFT : SQR_WAIT;
            SHIFT:    begin cnt_inc_s = 1'b1; state_d = CHECK; end
            DONE:     state_d = IDLE;
            ABORT:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
`ifdef RSA_EXP_ABORT_EN
        // Abort wins over any same-cycle multiplier completion.
        if (abort && (state_q != IDLE)) begin
            state_d   = ABORT;
            cnt_inc_s = 1'b0;
        end else begin
            state_d   = state_d;
        end
`endif
    end

    assign out_d = decode_outputs(state_d);

    // State and registered outputs; reset drives every output low.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign sr_ena    = out_q.sr_ena;
    assign sr_clear  = out_q.sr_clear;
    assign sr_load   = out_q.sr_load;
    assign mul_start = out_q.mul_start;
    assign mul_op    = out_q.mul_op;
    assign busy      = out_q.busy;
    assign done      = out_q.done;

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Scoreboard bench for rsa_exp_ctrl with WIDTH=4, shift register and multiplier models.
module tb_rsa_exp_ctrl;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          start = 1'b0;
    logic          sr_bit;
    logic          mul_done;
    logic          sr_ena, sr_clear, sr_load, mul_start, mul_op, busy, done;
    logic [CW-1:0] bit_idx;
`ifdef RSA_EXP_ABORT_EN
    logic          abort = 1'b0;
`endif

    logic          resp_done = 1'b0;
    logic          spur_done = 1'b0;
    logic [W-1:0]  sr_q = '0;
    logic [W-1:0]  exp_val = '0;
    int            lat = 3;
    bit            spur_en = 1'b0;

    typedef struct { int kind; int idx; } ev_t;
    ev_t q[$];
    int  n_cmp = 0;
    int  n_fail = 0;

    assign mul_done = resp_done | spur_done;
    assign sr_bit   = sr_q[0];

    rsa_exp_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .start     (start),
        .sr_bit    (sr_bit),
        .mul_done  (mul_done),
`ifdef RSA_EXP_ABORT_EN
        .abort     (abort),
`endif
        .sr_ena    (sr_ena),
        .sr_clear  (sr_clear),
        .sr_load   (sr_load),
        .mul_start (mul_start),
        .mul_op    (mul_op),
        .busy      (busy),
        .done      (done),
        .bit_idx   (bit_idx)
    );

    always #5 clk = ~clk;

    // LSB-first exponent shift register.
    always @(posedge clk) begin
        if (sr_ena) begin
            if (!sr_clear)    sr_q <= '0;
            else if (sr_load) sr_q <= exp_val;
            else              sr_q <= sr_q >> 1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_seq(input string ops, input string idxs);
        ev_t e;
        for (int i = 0; i < ops.len(); i++) begin
            e.kind = int'(ops[i]);
            e.idx  = int'(idxs[i]) - 48;
            q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, int'(seen), 1);
    endtask

    task automatic wait_mul(input logic op, input int budget, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (mul_start && mul_op == op) seen = 1'b1;
        end
        check({name, "_mul_seen"}, int'(seen), 1);
    endtask

    task automatic post_done(input string name);
        @(negedge clk);
        check({name, "_sr_wiped"}, int'(sr_q), 0);
        check({name, "_queue_empty"}, q.size(), 0);
        check({name, "_idle"}, int'(busy), 0);
    endtask

    // Multiplier model: completes lat cycles after each launch.
    initial forever begin
        @(negedge clk);
        resp_done = 1'b0;
        if (mul_start) begin
            repeat (lat) @(negedge clk);
            resp_done = 1'b1;
        end
    end

    // Spurious completion aimed at the CHECK cycle following a square (lat=1).
    initial forever begin
        @(negedge clk);
        spur_done = 1'b0;
        if (mul_start && mul_op && spur_en) begin
            repeat (3) @(negedge clk);
            spur_done = 1'b1;
        end
    end

    // Monitor: every launch and done is matched against the expected queue.
    initial forever begin
        ev_t e;
        @(negedge clk);
        if (mul_start || done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_event: mul_start=%0b done=%0b bit_idx=%0d, expected none",
                         mul_start, done, bit_idx);
            end else begin
                e = q.pop_front();
                if (mul_start) begin
                    check("op_kind", mul_op ? 83 : 77, e.kind);
                end else begin
                    check("done_kind", 68, e.kind);
                    check("done_sr_wipe", int'({sr_ena, sr_clear}), 2);
                end
                check("event_bit_idx", int'(bit_idx), e.idx);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset held with start asserted
        rstb = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_mul_start", int'(mul_start), 0);
        check("reset_sr_ena", int'(sr_ena), 0);
        check("reset_sr_clear", int'(sr_clear), 0);
        check("reset_bit_idx", int'(bit_idx), 0);
        start = 1'b0;
        rstb = 1'b1;
        @(negedge clk);
        check("idle_sr_clear", int'(sr_clear), 1);
        check("idle_busy", int'(busy), 0);

        // 1011, latency 3, start pulsed while busy
        exp_val = 4'b1011;
        lat = 3;
        push_seq("MSMSSMD", "0011233");
        pulse_start();
        check("t1_busy", int'(busy), 1);
        repeat (6) @(negedge clk);
        pulse_start();
        wait_done(200, "t1");
        post_done("t1");

        // 0000, start asserted in the DONE cycle
        exp_val = 4'b0000;
        push_seq("SSSD", "0123");
        pulse_start();
        wait_done(200, "t2");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t2_start_in_done_ignored", int'(busy), 0);
        check("t2_sr_wiped", int'(sr_q), 0);
        @(negedge clk);
        check("t2_still_idle", int'(busy), 0);

        // 1000
        exp_val = 4'b1000;
        push_seq("SSSMD", "01233");
        pulse_start();
        wait_done(200, "t3");
        post_done("t3");

        // 0110, earliest completion plus spurious pulse in CHECK
        exp_val = 4'b0110;
        lat = 1;
        spur_en = 1'b1;
        push_seq("SMSMSD", "011223");
        pulse_start();
        wait_done(200, "t4");
        post_done("t4");
        spur_en = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during SQR_WAIT
        exp_val = 4'b1011;
        lat = 3;
        push_seq("MSMSSMD", "0011233");
        pulse_start();
        wait_mul(1'b1, 50, "t5");
        @(negedge clk);
        q.delete();
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        check("t5_reset_busy", int'(busy), 0);
        check("t5_reset_done", int'(done), 0);
        check("t5_reset_mul_start", int'(mul_start), 0);
        repeat (10) @(negedge clk);
        check("t5_stays_idle", int'(busy), 0);

        // Fresh start after reset: 1111, latency 2
        exp_val = 4'b1111;
        lat = 2;
        push_seq("MSMSMSMD", "00112233");
        pulse_start();
        wait_done(200, "t6");
        post_done("t6");

`ifdef RSA_EXP_ABORT_EN
        // Abort coinciding with mul_done in MUL_WAIT
        exp_val = 4'b1011;
        lat = 3;
        push_seq("M", "0");
        pulse_start();
        wait_mul(1'b0, 50, "t7");
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t7_abort_sr_ena", int'(sr_ena), 1);
        check("t7_abort_sr_clear", int'(sr_clear), 0);
        check("t7_abort_done", int'(done), 0);
        check("t7_abort_mul_start", int'(mul_start), 0);
        check("t7_abort_busy", int'(busy), 1);
        @(negedge clk);
        check("t7_after_abort_idle", int'(busy), 0);
        repeat (10) @(negedge clk);
        check("t7_queue_empty", q.size(), 0);
        check("t7_stays_idle", int'(busy), 0);
`endif

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
